// File: rtl/mem_bus_arbiter.sv
// Shares one SRAM bus between instruction fetch and MEM-stage data access,
// sequences fixed-latency accesses and builds the pipeline stall vector.
module mem_bus_arbiter #(
    parameter int unsigned WAIT_STATES = 2  // extra bus cycles per access, 0..15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_inst,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [3:0]  mem_sel,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    input  logic        stallreq_id,
    input  logic        stallreq_ex,
    output logic [5:0]  stall,
    output logic        bus_ce,
    output logic        bus_we,
    output logic [3:0]  bus_sel,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    output logic [1:0]  dbg_state
);
    // Handshake: a port holds its request until the stall it causes is
    // released; the DONE cycle is the completion beat in which data is valid.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DACC = 2'd1,
        IACC = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        if_done_q, if_done_d;
    logic        mem_done_q, mem_done_d;
    logic        bus_ce_q, bus_ce_d;
    logic        bus_we_q, bus_we_d;
    logic [3:0]  bus_sel_q, bus_sel_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic [31:0] if_inst_q, if_inst_d;
    logic [31:0] mem_rdata_q, mem_rdata_d;
    logic        mem_stall, if_stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            if_done_q   <= 1'b0;
            mem_done_q  <= 1'b0;
            bus_ce_q    <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_sel_q   <= 4'h0;
            bus_addr_q  <= 32'h0;
            bus_wdata_q <= 32'h0;
            if_inst_q   <= 32'h0;
            mem_rdata_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            if_done_q   <= if_done_d;
            mem_done_q  <= mem_done_d;
            bus_ce_q    <= bus_ce_d;
            bus_we_q    <= bus_we_d;
            bus_sel_q   <= bus_sel_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            if_inst_q   <= if_inst_d;
            mem_rdata_q <= mem_rdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        if_done_d   = if_done_q;
        mem_done_d  = mem_done_q;
        bus_ce_d    = bus_ce_q;
        bus_we_d    = bus_we_q;
        bus_sel_d   = bus_sel_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        if_inst_d   = if_inst_q;
        mem_rdata_d = mem_rdata_q;
        case (state_q)
            IDLE: begin
                if (mem_req) begin
                    state_d     = DACC;
                    bus_ce_d    = 1'b1;
                    bus_we_d    = mem_we;
                    bus_sel_d   = mem_sel;
                    bus_addr_d  = mem_addr;
                    bus_wdata_d = mem_wdata;
                    cnt_d       = 4'(WAIT_STATES);
                end else if (if_req) begin
                    state_d    = IACC;
                    bus_ce_d   = 1'b1;
                    bus_we_d   = 1'b0;
                    bus_sel_d  = 4'hF;
                    bus_addr_d = if_addr;
                    cnt_d      = 4'(WAIT_STATES);
                end
            end
            DACC, IACC: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    if (state_q == DACC) begin
                        if (!bus_we_q) mem_rdata_d = bus_rdata;
                        mem_done_d = 1'b1;
                    end else begin
                        if_inst_d = bus_rdata;
                        if_done_d = 1'b1;
                    end
                    bus_ce_d  = 1'b0;
                    bus_we_d  = 1'b0;
                    bus_sel_d = 4'h0;
                    state_d   = DONE;
                end
            end
            // No grant here: the finishing request is still high this cycle.
            DONE: begin
                if_done_d  = 1'b0;
                mem_done_d = 1'b0;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign mem_stall = mem_req & ~mem_done_q;
    assign if_stall  = if_req & ~if_done_q;

    always_comb begin
        stall = 6'b000000;
        if (rst)              stall = 6'b000000;
        else if (mem_stall)   stall = 6'b011111;
        else if (stallreq_ex) stall = 6'b001111;
        else if (stallreq_id) stall = 6'b000111;
        else if (if_stall)    stall = 6'b000011;
    end

    assign if_inst   = if_inst_q;
    assign mem_rdata = mem_rdata_q;
    assign bus_ce    = bus_ce_q;
    assign bus_we    = bus_we_q;
    assign bus_sel   = bus_sel_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign dbg_state = state_q;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: per-cycle vector table on a WAIT_STATES=2
// instance plus a hand-written sequence on a WAIT_STATES=0 instance.
module tb_mem_bus_arbiter;
  localparam logic [1:0] S_IDLE = 2'd0, S_DACC = 2'd1, S_IACC = 2'd2, S_DONE = 2'd3;

  typedef struct {
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_sel;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        sid;
    logic        sex;
    logic [31:0] rdata;
    logic [5:0]  e_stall;
    logic        e_ce;
    logic        e_we;
    logic [3:0]  e_sel;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic [31:0] e_inst;
    logic [31:0] e_rdata;
    logic [1:0]  e_state;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, if_req, mem_req, mem_we, stallreq_id, stallreq_ex;
  logic [31:0] if_addr, mem_addr, mem_wdata, bus_rdata;
  logic [3:0]  mem_sel;
  logic [31:0] if_inst, mem_rdata, bus_addr, bus_wdata;
  logic [5:0]  stall;
  logic        bus_ce, bus_we;
  logic [3:0]  bus_sel;
  logic [1:0]  dbg_state;

  logic        z_rst, z_if_req, z_mem_req, z_mem_we, z_sid, z_sex;
  logic [31:0] z_if_addr, z_mem_addr, z_mem_wdata, z_bus_rdata;
  logic [3:0]  z_mem_sel;
  logic [31:0] z_if_inst, z_mem_rdata, z_bus_addr, z_bus_wdata;
  logic [5:0]  z_stall;
  logic        z_bus_ce, z_bus_we;
  logic [3:0]  z_bus_sel;
  logic [1:0]  z_dbg_state;

  mem_bus_arbiter #(.WAIT_STATES(2)) dut (
    .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .if_inst(if_inst),
    .mem_req(mem_req), .mem_we(mem_we), .mem_sel(mem_sel), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .stallreq_id(stallreq_id),
    .stallreq_ex(stallreq_ex), .stall(stall), .bus_ce(bus_ce), .bus_we(bus_we),
    .bus_sel(bus_sel), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .dbg_state(dbg_state)
  );

  mem_bus_arbiter #(.WAIT_STATES(0)) dut_z (
    .clk(clk), .rst(z_rst), .if_req(z_if_req), .if_addr(z_if_addr), .if_inst(z_if_inst),
    .mem_req(z_mem_req), .mem_we(z_mem_we), .mem_sel(z_mem_sel), .mem_addr(z_mem_addr),
    .mem_wdata(z_mem_wdata), .mem_rdata(z_mem_rdata), .stallreq_id(z_sid),
    .stallreq_ex(z_sex), .stall(z_stall), .bus_ce(z_bus_ce), .bus_we(z_bus_we),
    .bus_sel(z_bus_sel), .bus_addr(z_bus_addr), .bus_wdata(z_bus_wdata),
    .bus_rdata(z_bus_rdata), .dbg_state(z_dbg_state)
  );

  int total = 0;
  int bad = 0;
  vec_t vq[$];
  vec_t v;

  task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s row=%0d got=%h want=%h", name, row, act, exp);
    end
  endtask

  task automatic push_n(input int n);
    for (int k = 0; k < n; k++) vq.push_back(v);
  endtask

  initial begin
    // ---------------- vector table (WAIT_STATES=2) ----------------
    v = '{default: '0};
    v.rst = 1'b1;
    push_n(1);
    // single fetch
    v.rst = 1'b0; v.if_req = 1'b1; v.if_addr = 32'h40; v.rdata = 32'h3C010001;
    v.e_stall = 6'b000011; push_n(1);
    v.e_state = S_IACC; v.e_ce = 1'b1; v.e_sel = 4'hF; v.e_addr = 32'h40; push_n(3);
    v.e_state = S_DONE; v.e_ce = 1'b0; v.e_sel = 4'h0; v.e_inst = 32'h3C010001;
    v.e_stall = 6'b000000; push_n(1);
    v.if_req = 1'b0; v.e_state = S_IDLE; push_n(1);
    // load
    v.mem_req = 1'b1; v.mem_sel = 4'b0011; v.mem_addr = 32'h100; v.mem_wdata = 32'hAAAA5555;
    v.rdata = 32'hDEADBEEF; v.e_stall = 6'b011111; push_n(1);
    v.e_state = S_DACC; v.e_ce = 1'b1; v.e_sel = 4'b0011; v.e_addr = 32'h100;
    v.e_wdata = 32'hAAAA5555; push_n(3);
    v.e_state = S_DONE; v.e_ce = 1'b0; v.e_sel = 4'h0; v.e_rdata = 32'hDEADBEEF;
    v.e_stall = 6'b000000; push_n(1);
    v.mem_req = 1'b0; v.e_state = S_IDLE; push_n(1);
    // store and fetch in the same cycle
    v.mem_req = 1'b1; v.mem_we = 1'b1; v.mem_sel = 4'hF; v.mem_addr = 32'h200;
    v.mem_wdata = 32'h12345678; v.if_req = 1'b1; v.if_addr = 32'h44; v.rdata = 32'h0BADF00D;
    v.e_stall = 6'b011111; push_n(1);
    v.e_state = S_DACC; v.e_ce = 1'b1; v.e_we = 1'b1; v.e_sel = 4'hF; v.e_addr = 32'h200;
    v.e_wdata = 32'h12345678; push_n(3);
    v.e_state = S_DONE; v.e_ce = 1'b0; v.e_we = 1'b0; v.e_sel = 4'h0;
    v.e_stall = 6'b000011; push_n(1);
    v.mem_req = 1'b0; v.mem_we = 1'b0; v.e_state = S_IDLE; push_n(1);
    v.e_state = S_IACC; v.e_ce = 1'b1; v.e_sel = 4'hF; v.e_addr = 32'h44; push_n(3);
    v.e_state = S_DONE; v.e_ce = 1'b0; v.e_sel = 4'h0; v.e_inst = 32'h0BADF00D;
    v.e_stall = 6'b000000; push_n(1);
    v.if_req = 1'b0; v.e_state = S_IDLE; push_n(1);
    // ID/EX stall priority without bus activity
    v.sex = 1'b1; v.sid = 1'b1; v.e_stall = 6'b001111; push_n(1);
    v.sex = 1'b0; v.e_stall = 6'b000111; push_n(1);
    v.sid = 1'b0; v.e_stall = 6'b000000; push_n(1);
    // fetch dropped mid-access still completes, without stalling
    v.if_req = 1'b1; v.if_addr = 32'h48; v.rdata = 32'h11112222; v.e_stall = 6'b000011; push_n(1);
    v.if_req = 1'b0; v.e_state = S_IACC; v.e_ce = 1'b1; v.e_sel = 4'hF; v.e_addr = 32'h48;
    v.e_stall = 6'b000000; push_n(3);
    v.e_state = S_DONE; v.e_ce = 1'b0; v.e_sel = 4'h0; v.e_inst = 32'h11112222; push_n(1);
    v.e_state = S_IDLE; push_n(1);
    // mem stall outranks EX; then reset in the middle of the load
    v.mem_req = 1'b1; v.mem_sel = 4'hF; v.mem_addr = 32'h300; v.mem_wdata = 32'h0;
    v.sex = 1'b1; v.rdata = 32'h55667788; v.e_stall = 6'b011111; push_n(1);
    v.sex = 1'b0; v.e_state = S_DACC; v.e_ce = 1'b1; v.e_sel = 4'hF; v.e_addr = 32'h300;
    v.e_wdata = 32'h0; push_n(1);
    v.rst = 1'b1; v.e_stall = 6'b000000; push_n(1);
    v.rst = 1'b0; v.e_state = S_IDLE; v.e_ce = 1'b0; v.e_sel = 4'h0; v.e_addr = 32'h0;
    v.e_inst = 32'h0; v.e_rdata = 32'h0; v.e_stall = 6'b011111; push_n(1);
    v.e_state = S_DACC; v.e_ce = 1'b1; v.e_sel = 4'hF; v.e_addr = 32'h300; push_n(3);
    v.e_state = S_DONE; v.e_ce = 1'b0; v.e_sel = 4'h0; v.e_rdata = 32'h55667788;
    v.e_stall = 6'b000000; push_n(1);
    v.mem_req = 1'b0; v.e_state = S_IDLE; push_n(1);

    // ---------------- reset both instances ----------------
    rst = 1'b1; if_req = 1'b0; if_addr = '0; mem_req = 1'b0; mem_we = 1'b0; mem_sel = '0;
    mem_addr = '0; mem_wdata = '0; stallreq_id = 1'b0; stallreq_ex = 1'b0; bus_rdata = '0;
    z_rst = 1'b1; z_if_req = 1'b0; z_if_addr = '0; z_mem_req = 1'b0; z_mem_we = 1'b0;
    z_mem_sel = '0; z_mem_addr = '0; z_mem_wdata = '0; z_sid = 1'b0; z_sex = 1'b0;
    z_bus_rdata = '0;
    repeat (2) @(posedge clk);

    // ---------------- apply table ----------------
    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      rst = vq[i].rst; if_req = vq[i].if_req; if_addr = vq[i].if_addr;
      mem_req = vq[i].mem_req; mem_we = vq[i].mem_we; mem_sel = vq[i].mem_sel;
      mem_addr = vq[i].mem_addr; mem_wdata = vq[i].mem_wdata;
      stallreq_id = vq[i].sid; stallreq_ex = vq[i].sex; bus_rdata = vq[i].rdata;
      #1;
      chk("stall", i, 32'(stall), 32'(vq[i].e_stall));
      chk("bus_ce", i, 32'(bus_ce), 32'(vq[i].e_ce));
      chk("bus_we", i, 32'(bus_we), 32'(vq[i].e_we));
      chk("bus_sel", i, 32'(bus_sel), 32'(vq[i].e_sel));
      chk("bus_addr", i, bus_addr, vq[i].e_addr);
      chk("bus_wdata", i, bus_wdata, vq[i].e_wdata);
      chk("if_inst", i, if_inst, vq[i].e_inst);
      chk("mem_rdata", i, mem_rdata, vq[i].e_rdata);
      chk("state", i, 32'(dbg_state), 32'(vq[i].e_state));
    end

    // ---------------- WAIT_STATES=0 load, no re-grant in DONE ----------------
    @(negedge clk);
    z_rst = 1'b0; z_mem_req = 1'b1; z_mem_sel = 4'hF; z_mem_addr = 32'h80;
    z_bus_rdata = 32'hCAFE0001;
    #1;
    chk("z_idle_stall", 0, 32'(z_stall), 32'(6'b011111));
    chk("z_idle_ce", 0, 32'(z_bus_ce), 32'd0);
    @(negedge clk); #1;
    chk("z_acc_ce", 1, 32'(z_bus_ce), 32'd1);
    chk("z_acc_addr", 1, z_bus_addr, 32'h80);
    chk("z_acc_state", 1, 32'(z_dbg_state), 32'(S_DACC));
    chk("z_acc_stall", 1, 32'(z_stall), 32'(6'b011111));
    @(negedge clk); #1;
    chk("z_done_state", 2, 32'(z_dbg_state), 32'(S_DONE));
    chk("z_done_ce", 2, 32'(z_bus_ce), 32'd0);
    chk("z_done_rdata", 2, z_mem_rdata, 32'hCAFE0001);
    chk("z_done_stall", 2, 32'(z_stall), 32'(6'b000000));
    @(negedge clk);
    z_mem_req = 1'b0;
    #1;
    chk("z_after_state", 3, 32'(z_dbg_state), 32'(S_IDLE));
    chk("z_after_ce", 3, 32'(z_bus_ce), 32'd0);
    chk("z_after_stall", 3, 32'(z_stall), 32'(6'b000000));
    @(negedge clk); #1;
    chk("z_quiet_ce", 4, 32'(z_bus_ce), 32'd0);
    chk("z_quiet_state", 4, 32'(z_dbg_state), 32'(S_IDLE));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
